// File: rtl/joy_pkg.sv
// Shared definitions for the joystick splitter scanner.
//
// Contents:
//   joy_state_e   - scan FSM states (settle after a select change, then sample)
//   JOY_RELEASED  - all-ones button vector (every active-low line released)
//   clog2         - constant ceil(log2) helper used for register widths
package joy_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } joy_state_e;

    localparam int MAX_BUTTONS = 8;
    localparam logic [MAX_BUTTONS-1:0] JOY_RELEASED = '1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-port debouncer for the joystick splitter scanner.
//
// A sample must repeat DEBOUNCE_SAMPLES times in a row before it is committed
// to value_o. clear_i restarts the qualification (candidate released, count 0);
// if release_i is also high the committed value is forced back to released.
//
// Ports:
//   clk, reset_n    - system clock, asynchronous active-low reset
//   clear_i         - restart qualification (mode change)
//   release_i       - with clear_i, also release the committed value
//   sample_valid_i  - sample_i carries a new sample for this port
//   sample_i        - synchronised button lines, active-low
//   value_o         - committed (debounced) button lines, active-low
module joy_debounce
    import joy_pkg::*;
#(
    parameter int BUTTONS          = 5,
    parameter int DEBOUNCE_SAMPLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               release_i,
    input  logic               sample_valid_i,
    input  logic [BUTTONS-1:0] sample_i,
    output logic [BUTTONS-1:0] value_o
);

    localparam int CNT_W = clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [BUTTONS-1:0] RELEASED = JOY_RELEASED[BUTTONS-1:0];

    logic [BUTTONS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUTTONS-1:0] value_q, value_d;

    // The count saturates at CNT_MAX so a steady input keeps re-committing
    // the same value instead of wrapping and re-qualifying.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        if (clear_i) begin
            cand_d = RELEASED;
            cnt_d  = '0;
            if (release_i) begin
                value_d = RELEASED;
            end
        end else if (sample_valid_i) begin
            if (sample_i == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = sample_i;
                cnt_d  = CNT_W'(1);
            end
            if (cnt_d == CNT_MAX) begin
                value_d = cand_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q  <= RELEASED;
            cnt_q   <= '0;
            value_q <= RELEASED;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/joy_splitter_scan.sv
// Joystick-port scanner: time-multiplexes NUM_PORTS DB9 joysticks through one
// shared set of active-low button lines using the joy_sel output.
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   joy_in       - raw connector lines, active-low, asynchronous
//   mode_tg      - level; each rising edge toggles split mode
//   joy_sel      - inverted port index driven to the splitter hardware
//   split_active - current mode (1 = all ports scanned, 0 = port 0 only)
//   joy_out      - debounced lines, port p at [p*BUTTONS +: BUTTONS]
//   scan_done    - one-cycle pulse after the last port of a scan is sampled
module joy_splitter_scan
    import joy_pkg::*;
#(
    parameter int NUM_PORTS        = 2,
    parameter int BUTTONS          = 5,
    parameter int CLK_DIV          = 128,
    parameter int SETTLE_TICKS     = 1,
    parameter int DEBOUNCE_SAMPLES = 2,
    parameter bit SPLIT_DEFAULT    = 1'b0,
    localparam int SEL_W = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [BUTTONS-1:0]           joy_in,
    input  logic                         mode_tg,
    output logic [SEL_W-1:0]             joy_sel,
    output logic                         split_active,
    output logic [NUM_PORTS*BUTTONS-1:0] joy_out,
    output logic                         scan_done
);

    localparam int PRESC_W  = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
    localparam int SETTLE_W = (clog2(SETTLE_TICKS) < 1) ? 1 : clog2(SETTLE_TICKS);
    localparam logic [SEL_W-1:0]    LAST_PORT   = SEL_W'(NUM_PORTS - 1);
    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(CLK_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);
    localparam logic [BUTTONS-1:0]  RELEASED    = JOY_RELEASED[BUTTONS-1:0];

    logic [BUTTONS-1:0]  sync1_q, sync2_q;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick;
    logic                modePrev_q;
    logic                modeRise;
    logic                split_q, split_d;
    joy_state_e          state_q, state_d;
    logic [SEL_W-1:0]    portIdx_q, portIdx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                scanDone_q, scanDone_d;
    logic                sampleEn;

    assign tick     = (presc_q == PRESC_LAST);
    assign presc_d  = tick ? '0 : presc_q + 1'b1;
    assign modeRise = mode_tg & ~modePrev_q;
    assign split_d  = split_q ^ modeRise;

    // modePrev_q resets high so a mode_tg already held high while reset is
    // released is not taken as a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            presc_q    <= '0;
            modePrev_q <= 1'b1;
            split_q    <= SPLIT_DEFAULT;
            scanDone_q <= 1'b0;
        end else begin
            sync1_q    <= joy_in;
            sync2_q    <= sync1_q;
            presc_q    <= presc_d;
            modePrev_q <= mode_tg;
            split_q    <= split_d;
            scanDone_q <= scanDone_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SETTLE;
            portIdx_q <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            portIdx_q <= portIdx_d;
            settle_q  <= settle_d;
        end
    end

    // A mode change takes priority over any tick: the scan restarts at port 0.
    always_comb begin
        state_d   = state_q;
        portIdx_d = portIdx_q;
        settle_d  = settle_q;
        if (modeRise) begin
            state_d   = ST_SETTLE;
            portIdx_d = '0;
            settle_d  = '0;
        end else if (tick) begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    state_d = ST_SETTLE;
                    if (split_q && (portIdx_q != LAST_PORT)) begin
                        portIdx_d = portIdx_q + 1'b1;
                    end else begin
                        portIdx_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SETTLE;
                end
            endcase
        end
    end

    // The sample that coincides with a mode edge is discarded.
    always_comb begin
        joy_sel    = ~portIdx_q;
        sampleEn   = (state_q == ST_SAMPLE) && tick && !modeRise;
        scanDone_d = sampleEn && (!split_q || (portIdx_q == LAST_PORT));
    end

    // Ports above 0 are released when single mode is entered; they are never
    // sampled in single mode so they stay released until split mode returns.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_port
        joy_debounce #(
            .BUTTONS          (BUTTONS),
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
        ) u_debounce (
            .clk            (clk),
            .reset_n        (reset_n),
            .clear_i        (modeRise),
            .release_i      (split_q && (p != 0)),
            .sample_valid_i (sampleEn && (portIdx_q == SEL_W'(p))),
            .sample_i       (sync2_q),
            .value_o        (joy_out[p*BUTTONS +: BUTTONS])
        );
    end

    assign split_active = split_q;
    assign scan_done    = scanDone_q;

endmodule

// File: tb/tb_joy_splitter_scan.sv
// Self-checking bench for joy_splitter_scan with NUM_PORTS=2, BUTTONS=5,
// CLK_DIV=4, SETTLE_TICKS=1, DEBOUNCE_SAMPLES=2. After reset release the
// prescaler ticks on cycles 3,7,11,...; "interval n" is the span before the
// n-th rising edge after release, and all checks are taken on falling edges.
module tb_joy_splitter_scan;

    localparam int NUM_PORTS = 2;
    localparam int BUTTONS   = 5;

    typedef struct {
        logic [4:0] joyIn;
        logic [4:0] expPort0;
    } slot_vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] joy_in;
    logic       mode_tg;
    logic [0:0] joy_sel;
    logic       split_active;
    logic [9:0] joy_out;
    logic       scan_done;

    logic       muxMode;
    logic [4:0] joyDirect;
    logic [4:0] muxA;
    logic [4:0] muxB;

    int checkCount = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int intervalNow = 0;

    slot_vec_t vecs [10];

    joy_splitter_scan #(
        .NUM_PORTS        (NUM_PORTS),
        .BUTTONS          (BUTTONS),
        .CLK_DIV          (4),
        .SETTLE_TICKS     (1),
        .DEBOUNCE_SAMPLES (2),
        .SPLIT_DEFAULT    (1'b0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .joy_in       (joy_in),
        .mode_tg      (mode_tg),
        .joy_sel      (joy_sel),
        .split_active (split_active),
        .joy_out      (joy_out),
        .scan_done    (scan_done)
    );

    // Emulates the splitter hardware: the connector shows whichever port the
    // select line currently addresses (joy_sel=1 -> port 0).
    assign joy_in = muxMode ? (joy_sel[0] ? muxA : muxB) : joyDirect;

    always #5 clk = ~clk;

    // Counts scan_done pulses; read at posedge so the value is pre-update.
    always @(posedge clk) begin
        if (reset_n && scan_done) begin
            doneCount <= doneCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] value);
        joyDirect = value;
    endtask

    task automatic stepTo(input int target);
        while (intervalNow < target) begin
            @(negedge clk);
            intervalNow++;
        end
    endtask

    initial begin
        vecs[0] = '{5'h1E, 5'h1F};
        vecs[1] = '{5'h1E, 5'h1E};
        vecs[2] = '{5'h1B, 5'h1E};
        vecs[3] = '{5'h1F, 5'h1E};
        vecs[4] = '{5'h1F, 5'h1F};
        vecs[5] = '{5'h1B, 5'h1F};
        vecs[6] = '{5'h1B, 5'h1B};
        vecs[7] = '{5'h00, 5'h1B};
        vecs[8] = '{5'h00, 5'h00};
        vecs[9] = '{5'h00, 5'h00};

        reset_n = 1'b0;
        mode_tg = 1'b0;
        muxMode = 1'b0;
        muxA    = 5'h1D;
        muxB    = 5'h0F;
        applyStimulus(5'h1F);
        repeat (3) @(negedge clk);

        checkOutput("reset_joy_out", 32'(joy_out), 32'h3FF);
        checkOutput("reset_joy_sel", 32'(joy_sel), 32'h1);
        checkOutput("reset_split", 32'(split_active), 32'h0);
        checkOutput("reset_scan_done", 32'(scan_done), 32'h0);

        // Single mode: one table entry per 8-cycle slot, checked just after
        // that slot's sample has had its cycle to commit.
        reset_n = 1'b1;
        intervalNow = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].joyIn);
            stepTo(8 * k + 8);
            checkOutput($sformatf("single_port0_slot%0d", k), 32'(joy_out[4:0]), 32'(vecs[k].expPort0));
            checkOutput($sformatf("single_port1_slot%0d", k), 32'(joy_out[9:5]), 32'h1F);
            checkOutput($sformatf("single_sel_slot%0d", k), 32'(joy_sel), 32'h1);
            checkOutput($sformatf("single_split_slot%0d", k), 32'(split_active), 32'h0);
            checkOutput($sformatf("single_done_slot%0d", k), 32'(scan_done), 32'h1);
        end
        checkOutput("single_done_count", 32'(doneCount), 32'd9);

        // Enter split mode at the start of a slot.
        mode_tg = 1'b1;
        muxMode = 1'b1;
        stepTo(81);
        checkOutput("split_on", 32'(split_active), 32'h1);
        checkOutput("split_sel_p0", 32'(joy_sel), 32'h1);
        stepTo(90);
        checkOutput("split_sel_p1", 32'(joy_sel), 32'h0);
        stepTo(96);
        checkOutput("split_port0_hold", 32'(joy_out[4:0]), 32'h00);
        checkOutput("split_done_p1", 32'(scan_done), 32'h1);
        stepTo(98);
        checkOutput("split_sel_p0_again", 32'(joy_sel), 32'h1);
        stepTo(100);
        mode_tg = 1'b0;
        stepTo(104);
        checkOutput("split_port0_commit", 32'(joy_out[4:0]), 32'h1D);
        checkOutput("split_port1_pending", 32'(joy_out[9:5]), 32'h1F);
        checkOutput("split_no_done_p0", 32'(scan_done), 32'h0);
        stepTo(112);
        checkOutput("split_both_ports", 32'(joy_out), 32'h1FD);
        checkOutput("split_done_second", 32'(scan_done), 32'h1);

        // Leave split mode mid-slot (port 0 SAMPLE state).
        stepTo(117);
        mode_tg = 1'b1;
        muxMode = 1'b0;
        applyStimulus(5'h17);
        stepTo(118);
        checkOutput("exit_split", 32'(split_active), 32'h0);
        checkOutput("exit_port1_released", 32'(joy_out[9:5]), 32'h1F);
        checkOutput("exit_sel", 32'(joy_sel), 32'h1);
        checkOutput("exit_port0_hold", 32'(joy_out[4:0]), 32'h1D);
        stepTo(124);
        mode_tg = 1'b0;
        checkOutput("exit_one_sample", 32'(joy_out[4:0]), 32'h1D);
        checkOutput("exit_done", 32'(scan_done), 32'h1);
        stepTo(132);
        checkOutput("exit_two_samples", 32'(joy_out[4:0]), 32'h17);
        checkOutput("exit_port1_still", 32'(joy_out[9:5]), 32'h1F);

        // Mode edge lands exactly on a sample tick that would otherwise commit.
        applyStimulus(5'h0A);
        stepTo(140);
        checkOutput("coinc_first_sample", 32'(joy_out[4:0]), 32'h17);
        stepTo(147);
        mode_tg = 1'b1;
        stepTo(148);
        checkOutput("coinc_split", 32'(split_active), 32'h1);
        checkOutput("coinc_discarded", 32'(joy_out[4:0]), 32'h17);
        checkOutput("coinc_no_done", 32'(scan_done), 32'h0);
        checkOutput("coinc_sel_p0", 32'(joy_sel), 32'h1);
        stepTo(156);
        checkOutput("coinc_count_cleared", 32'(joy_out[4:0]), 32'h17);
        stepTo(160);
        checkOutput("coinc_sel_p1", 32'(joy_sel), 32'h0);
        stepTo(172);
        checkOutput("coinc_commit", 32'(joy_out[4:0]), 32'h0A);

        // Asynchronous reset in the middle of port 1's SAMPLE state.
        stepTo(177);
        checkOutput("pre_reset_out", 32'(joy_out), 32'h3EA);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 32'(joy_out), 32'h3FF);
        checkOutput("async_reset_sel", 32'(joy_sel), 32'h1);
        checkOutput("async_reset_split", 32'(split_active), 32'h0);
        checkOutput("async_reset_done", 32'(scan_done), 32'h0);
        #20;

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
